// File: rtl/i2c_pkg.sv
// Shared types for the I2C command sequencer.
// Command words are packed {rd_wr, addr, data}.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int CMD_W  = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  typedef struct packed {
    logic              rd_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  function automatic cmd_t pack_cmd(
    input logic              rd_wr,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    cmd_t c;
    c.rd_wr = rd_wr;
    c.addr  = addr;
    c.data  = data;
    return c;
  endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers.
// Head word is shown combinationally on rdata.
module i2c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign level = wptr - rptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wptr == rptr);

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Queues host I2C transactions, feeds them to the master one at a time
// and collects read bytes; a watchdog aborts a stalled master.
module i2c_cmd_sequencer
  import i2c_pkg::*;
#(
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rd_wr,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [DATA_W-1:0]           cmd_data,
  output logic [$clog2(CMD_DEPTH):0]  cmd_level,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [ADDR_W-1:0]           m_addr,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_rd_wr,
  output logic                        m_enable,
  input  logic                        m_ready,
  input  logic [DATA_W-1:0]           m_data_out,
  output logic                        busy,
  output logic                        timeout_err,
  input  logic                        clr_err
);

  localparam int RSP_LW = $clog2(RSP_DEPTH) + 1;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  state_t state, state_n;

  logic [WD_W-1:0]   cnt, cnt_n;
  logic              en_n, rw_n, err_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n;
  logic              up;

  cmd_t              cmd_in, cmd_head;
  logic              cmd_push, cmd_pop;
  logic              cmd_full, cmd_empty;

  logic              rsp_wr, rsp_push, rsp_pop;
  logic [DATA_W-1:0] rsp_wdata;
  logic [RSP_LW-1:0] rsp_level;
  logic              rsp_full, rsp_empty;

  logic              wd_hit, can_issue;

  assign cmd_in    = pack_cmd(cmd_rd_wr, cmd_addr, cmd_data);
  assign cmd_ready = up & ~cmd_full;
  assign cmd_push  = cmd_valid & cmd_ready;

  assign rsp_valid = ~rsp_empty;
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign rsp_push  = rsp_wr & ~rsp_full;

  assign busy   = (state != S_IDLE) | ~cmd_empty;
  assign wd_hit = (cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Reads only go out when their response slot is already free
  assign can_issue = ~cmd_empty & m_ready &
                     (~cmd_head.rd_wr |
                      (rsp_level < RSP_LW'(RSP_DEPTH)));

  i2c_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .wdata (cmd_in),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .level (cmd_level),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  i2c_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .wdata (rsp_wdata),
    .pop   (rsp_pop),
    .rdata (rsp_data),
    .level (rsp_level),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      m_enable    <= 1'b0;
      m_addr      <= '0;
      m_data      <= '0;
      m_rd_wr     <= 1'b0;
      timeout_err <= 1'b0;
      up          <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      m_enable    <= en_n;
      m_addr      <= addr_n;
      m_data      <= data_n;
      m_rd_wr     <= rw_n;
      timeout_err <= err_n;
      up          <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    en_n      = m_enable;
    addr_n    = m_addr;
    data_n    = m_data;
    rw_n      = m_rd_wr;
    err_n     = timeout_err & ~clr_err;
    cmd_pop   = 1'b0;
    rsp_wr    = 1'b0;
    rsp_wdata = m_data_out;
    unique case (state)
      S_IDLE: begin
        if (can_issue) begin
          cmd_pop = 1'b1;
          addr_n  = cmd_head.addr;
          data_n  = cmd_head.data;
          rw_n    = cmd_head.rd_wr;
          en_n    = 1'b1;
          cnt_n   = '0;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (!m_ready) begin
          en_n    = 1'b0;
          cnt_n   = '0;
          state_n = S_BUSY;
        end else if (wd_hit) begin
          en_n      = 1'b0;
          err_n     = 1'b1;
          rsp_wr    = m_rd_wr;
          rsp_wdata = 8'hFF;
          state_n   = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_BUSY: begin
        if (m_ready) begin
          rsp_wr  = m_rd_wr;
          state_n = S_IDLE;
        end else if (wd_hit) begin
          // Filler byte keeps responses 1:1 with reads
          en_n      = 1'b0;
          err_n     = 1'b1;
          rsp_wr    = m_rd_wr;
          rsp_wdata = 8'hFF;
          state_n   = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        en_n    = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: behavioural master, host queues and
// an in-order command/response reference model.
module tb_i2c_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rd_wr;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [2:0] cmd_level;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic       m_rd_wr;
  logic       m_enable;
  logic       m_ready;
  logic [7:0] m_data_out;
  logic       busy;
  logic       timeout_err;
  logic       clr_err;

  always #5 clk = ~clk;

  i2c_cmd_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rd_wr   (cmd_rd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_level   (cmd_level),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .m_addr      (m_addr),
    .m_data      (m_data),
    .m_rd_wr     (m_rd_wr),
    .m_enable    (m_enable),
    .m_ready     (m_ready),
    .m_data_out  (m_data_out),
    .busy        (busy),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  typedef struct {
    bit       rd;
    bit [6:0] a;
    bit [7:0] d;
  } tcmd_t;

  int errors = 0;
  int checks = 0;

  tcmd_t    cmd_q[$];
  bit [7:0] rsp_q[$];

  bit       hang = 0;
  bit       blk = 0;
  bit       lvl_chk = 0;
  bit       rnd_t = 0;
  bit       auto_pop = 0;
  bit       m_idle = 1;
  int       drop_d = 3;
  int       hold_d = 40;
  bit [7:0] next_rd = 8'h3C;
  int       n_iss = 0;
  int       en_len = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural I2C master
  initial begin : master
    tcmd_t    tc;
    int       d, h;
    bit [7:0] rv;
    bit       rd;
    m_ready    = 1'b1;
    m_data_out = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (m_enable === 1'b1) begin
        m_idle = 0;
        n_iss++;
        if (cmd_q.size() == 0) begin
          chk("iss_extra", 1, 0);
        end else begin
          tc = cmd_q.pop_front();
          chk("iss_rw", m_rd_wr, tc.rd);
          chk("iss_addr", m_addr, tc.a);
          if (!tc.rd) chk("iss_data", m_data, tc.d);
        end
        if (lvl_chk) chk("lvl_dec", cmd_level, cmd_q.size());
        rd = m_rd_wr;
        if (hang) begin
          if (rd) rsp_q.push_back(8'hFF);
          en_len = 1;
          while (m_enable === 1'b1 && en_len < 3000) begin
            @(posedge clk); #1;
            if (m_enable === 1'b1) en_len++;
          end
        end else begin
          if (rnd_t) begin
            d  = $urandom_range(1, 4);
            h  = $urandom_range(1, 6);
            rv = 8'($urandom);
          end else begin
            d  = drop_d;
            h  = hold_d;
            rv = next_rd;
          end
          repeat (d) @(posedge clk);
          #1;
          m_ready = 1'b0;
          chk("en_hold", m_enable, 1);
          @(posedge clk); #1;
          chk("en_fall", m_enable, 0);
          repeat (h - 1) @(posedge clk);
          #1;
          if (rd) rsp_q.push_back(rv);
          m_data_out = rv;
          m_ready    = 1'b1;
          if (rd) begin
            @(posedge clk); #1;
            chk("rsp_lat", rsp_valid, 1);
          end
        end
        m_idle = 1;
      end
      if (m_enable !== 1'b1) m_ready = !blk;
    end
  end

  task automatic pop();
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (rsp_valid !== 1'b1) begin
      chk("pop_wait", rsp_valid, 1);
      return;
    end
    if (rsp_q.size() == 0) chk("rsp_extra", 1, 0);
    else chk("rsp_data", rsp_data, rsp_q.pop_front());
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic push(input bit rd, input bit [6:0] a, input bit [7:0] d);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 3000) begin
      if (auto_pop && rsp_valid === 1'b1) pop();
      else begin
        @(posedge clk); #1;
      end
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("push_wait", cmd_ready, 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_rd_wr = rd;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_q.push_back('{rd, a, d});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic idle_wait();
    int n = 0;
    while ((busy !== 1'b0 || !m_idle) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", busy !== 1'b0 || !m_idle, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

  initial begin : main
    int iss0;
    int n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_rd_wr = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    clr_err   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_m_enable", m_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_level", cmd_level, 0);
    chk("rst_m_bus", {m_rd_wr, m_addr, m_data}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", cmd_ready, 1);

    // Single write
    push(0, 7'h50, 8'hA5);
    idle_wait();
    chk("wr_no_rsp", rsp_valid, 0);
    chk("wr_busy", busy, 0);

    // Single read
    next_rd = 8'h3C;
    push(1, 7'h51, 8'h00);
    idle_wait();
    pop();

    // Fill command FIFO while master is not ready
    blk    = 1;
    drop_d = 1;
    hold_d = 2;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      push(0, 7'(7'h20 + i), 8'($urandom));
      chk("fill_level", cmd_level, i + 1);
    end
    chk("full_ready", cmd_ready, 0);
    lvl_chk = 1;
    blk     = 0;
    idle_wait();
    lvl_chk = 0;
    chk("drain_ready", cmd_ready, 1);

    // Response FIFO back-pressure holds the fifth read
    rnd_t = 1;
    iss0  = n_iss;
    for (int i = 0; i < 5; i++) push(1, 7'(7'h30 + i), 8'h00);
    repeat (150) @(posedge clk);
    #1;
    chk("rd5_held_lvl", cmd_level, 1);
    chk("rd5_held_iss", n_iss - iss0, 4);
    pop();
    for (int i = 0; i < 4; i++) pop();
    idle_wait();
    chk("rd5_iss", n_iss - iss0, 5);
    chk("rd5_empty", rsp_valid, 0);

    // Watchdog abort on a read
    hang = 1;
    push(1, 7'h52, 8'h00);
    idle_wait();
    hang = 0;
    chk("wd_len", en_len, 1024);
    chk("wd_err", timeout_err, 1);
    chk("wd_enable", m_enable, 0);
    pop();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("clr_err", timeout_err, 0);

    // Reset in S_BUSY with two commands queued
    rnd_t  = 0;
    drop_d = 2;
    hold_d = 100;
    push(0, 7'h60, 8'h11);
    repeat (10) @(posedge clk);
    #1;
    push(0, 7'h61, 8'h22);
    push(0, 7'h62, 8'h33);
    chk("mid_level", cmd_level, 2);
    chk("mid_busy", busy, 1);
    iss0 = n_iss;
    rst  = 1'b1;
    @(posedge clk); #1;
    chk("mrst_enable", m_enable, 0);
    chk("mrst_level", cmd_level, 0);
    chk("mrst_ready", cmd_ready, 0);
    chk("mrst_rsp", rsp_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_bus", {m_rd_wr, m_addr, m_data}, 0);
    rst = 1'b0;
    cmd_q.delete();
    repeat (150) @(posedge clk);
    #1;
    chk("mrst_no_iss", n_iss - iss0, 0);
    chk("mrst_idle", busy, 0);
    chk("mrst_up", cmd_ready, 1);

    // Randomized traffic
    rnd_t    = 1;
    auto_pop = 1;
    for (int i = 0; i < 40; i++) begin
      push(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1 && rsp_valid === 1'b1) pop();
    end
    n = 0;
    while ((rsp_q.size() != 0 || busy !== 1'b0 || !m_idle) && n < 5000) begin
      if (rsp_valid === 1'b1) pop();
      else begin
        @(posedge clk); #1;
      end
      n++;
    end
    chk("rnd_rsp_left", rsp_q.size(), 0);
    chk("rnd_cmd_left", cmd_q.size(), 0);
    chk("rnd_rsp_valid", rsp_valid, 0);
    chk("rnd_err", timeout_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
